// File: rtl/racing_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : racing_pkg                                                 |
// | Description : Shared pixel-format constants, game state encoding and the |
// |               transparency test used by the racing display pipeline.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package racing_pkg;

   localparam int PIX_W = 12;

   // Black and white are the sprite transparency keys.
   localparam logic [PIX_W-1:0] COLOR_BLACK = 12'h000;
   localparam logic [PIX_W-1:0] COLOR_WHITE = 12'hFFF;

   typedef enum logic [1:0] {
      PLAY      = 2'd0,
      GAME_OVER = 2'd1,
      CLEAR     = 2'd2
   } game_state_t;

   // A sprite pixel is drawn only when it is neither transparency key.
   function automatic logic opaque(input logic [PIX_W-1:0] color);
      return (color != COLOR_BLACK) && (color != COLOR_WHITE);
   endfunction

endpackage : racing_pkg
`default_nettype wire

// File: rtl/banner_overlay.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : banner_overlay                                             |
// | Description : Two-stage GAME OVER banner pipeline. Stage 0 tests the     |
// |               scan position against the banner window and forms the     |
// |               banner ROM address; stage 1 turns the ROM grey nibble into |
// |               an RGB444 overlay pixel.                                   |
// | Ports       : clk, reset_n         - pixel clock, async active-low reset |
// |               pix_row, pix_col     - current scan position               |
// |               video_on             - visible pixel                       |
// |               show                 - banner enabled this cycle           |
// |               rom_addr / rom_data  - banner ROM interface                |
// |               overlay_valid/_pix   - overlay output, 2 cycles after scan |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module banner_overlay
   import racing_pkg::*;
#(
   parameter int BANNER_X = 243,
   parameter int BANNER_Y = 232,
   parameter int BANNER_W = 135,
   parameter int BANNER_H = 16,
   parameter int ROM_AW   = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [9:0]        pix_row,
   input  logic [9:0]        pix_col,
   input  logic              video_on,
   input  logic              show,
   input  logic [3:0]        rom_data,
   output logic [ROM_AW-1:0] rom_addr,
   output logic              overlay_valid,
   output logic [PIX_W-1:0]  overlay_pix
);

   localparam logic [9:0] c_X0 = 10'(BANNER_X);
   localparam logic [9:0] c_X1 = 10'(BANNER_X + BANNER_W);
   localparam logic [9:0] c_Y0 = 10'(BANNER_Y);
   localparam logic [9:0] c_Y1 = 10'(BANNER_Y + BANNER_H);

   logic              w_in_win;
   logic [3:0]        w_row_off;
   logic [7:0]        w_col_off;
   logic              w_s1_valid;

   logic              r_in_win_d;
   logic              r_video_on_d;
   logic [ROM_AW-1:0] r_rom_addr;
   logic              r_overlay_valid;
   logic [PIX_W-1:0]  r_overlay_pix;

   assign w_in_win  = (pix_row >= c_Y0) && (pix_row < c_Y1) &&
                      (pix_col >= c_X0) && (pix_col < c_X1);
   // Banner is at most 16 rows by 256 columns, so the low offset bits
   // address it completely.
   assign w_row_off = 4'(pix_row - c_Y0);
   assign w_col_off = 8'(pix_col - c_X0);

   // rom_data belongs to the address registered in stage 0.
   assign w_s1_valid = r_in_win_d & r_video_on_d & show;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_in_win_d      <= 1'b0;
         r_video_on_d    <= 1'b0;
         r_rom_addr      <= '0;
         r_overlay_valid <= 1'b0;
         r_overlay_pix   <= '0;
      end else begin
         r_in_win_d   <= w_in_win;
         r_video_on_d <= video_on;
         // Outside the window the address is left alone so the ROM does not toggle.
         if (w_in_win) begin
            r_rom_addr <= ROM_AW'({w_row_off, w_col_off});
         end
         r_overlay_valid <= w_s1_valid;
         r_overlay_pix   <= w_s1_valid ? {rom_data, rom_data, rom_data} : '0;
      end
   end

   assign rom_addr      = r_rom_addr;
   assign overlay_valid = r_overlay_valid;
   assign overlay_pix   = r_overlay_pix;

endmodule : banner_overlay
`default_nettype wire

// File: rtl/collision_game_over_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : collision_game_over_ctrl                                   |
// | Description : Frame-confirmed collision detector. Checks the player car  |
// |               against NUM_CARS moving-car layers each pixel, declares    |
// |               GAME OVER after HIT_FRAMES consecutive overlapping frames, |
// |               flashes a ROM banner and returns to play on restart.       |
// | Ports       : clk, reset_n        - pixel clock, async active-low reset  |
// |               pix_row/pix_col     - scan position, video_on visible      |
// |               frame_tick, restart - single-cycle control pulses          |
// |               player_pix, car_pix - sprite layers (RGB444)               |
// |               rom_addr, rom_data  - banner ROM                           |
// |               collision_flag, hit_mask, game_state - game status         |
// |               overlay_valid, overlay_pix - banner overlay to colour mux  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module collision_game_over_ctrl
   import racing_pkg::*;
#(
   parameter int NUM_CARS     = 4,
   parameter int HIT_FRAMES   = 2,
   parameter int FLASH_FRAMES = 32,
   parameter int BANNER_X     = 243,
   parameter int BANNER_Y     = 232,
   parameter int BANNER_W     = 135,
   parameter int BANNER_H     = 16,
   parameter int ROM_AW       = 12
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [9:0]                pix_row,
   input  logic [9:0]                pix_col,
   input  logic                      video_on,
   input  logic                      frame_tick,
   input  logic                      restart,
   input  logic [PIX_W-1:0]          player_pix,
   input  logic [PIX_W*NUM_CARS-1:0] car_pix,
   output logic [ROM_AW-1:0]         rom_addr,
   input  logic [3:0]                rom_data,
   output logic                      collision_flag,
   output logic [NUM_CARS-1:0]       hit_mask,
   output logic [1:0]                game_state,
   output logic                      overlay_valid,
   output logic [PIX_W-1:0]          overlay_pix
);

   localparam int c_CNT_W   = $clog2(HIT_FRAMES + 1);
   localparam int c_FLASH_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
   localparam logic [c_CNT_W-1:0]   c_HIT_LAST   = c_CNT_W'(HIT_FRAMES - 1);
   localparam logic [c_FLASH_W-1:0] c_FLASH_LAST = c_FLASH_W'(FLASH_FRAMES - 1);

   game_state_t          r_state, w_state_nxt;
   logic [c_CNT_W-1:0]   r_hit_cnt, w_hit_cnt_nxt;
   logic [NUM_CARS-1:0]  r_hit_mask, w_hit_mask_nxt;
   logic                 r_collision_flag, w_flag_nxt;
   logic [c_FLASH_W-1:0] r_flash_cnt, w_flash_cnt_nxt;
   logic                 r_flash_hidden, w_flash_hidden_nxt;
   logic [NUM_CARS-1:0]  r_frame_hit_mask;

   logic                 w_player_opaque;
   logic [NUM_CARS-1:0]  w_car_hit;
   logic                 w_show;

   // ---------------------------------------------------------------- detector
   assign w_player_opaque = video_on & opaque(player_pix);

   generate
      for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_car_hit
         assign w_car_hit[gi] = w_player_opaque & opaque(car_pix[PIX_W*gi +: PIX_W]);
      end
   endgenerate

   // Accumulator restarts on every frame_tick; ticks fall in vertical blank,
   // so nothing visible is lost by ignoring hits in the tick cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_hit_mask <= '0;
      end else if (frame_tick) begin
         r_frame_hit_mask <= '0;
      end else begin
         r_frame_hit_mask <= r_frame_hit_mask | w_car_hit;
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state          <= PLAY;
         r_hit_cnt        <= '0;
         r_hit_mask       <= '0;
         r_collision_flag <= 1'b0;
         r_flash_cnt      <= '0;
         r_flash_hidden   <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_hit_cnt        <= w_hit_cnt_nxt;
         r_hit_mask       <= w_hit_mask_nxt;
         r_collision_flag <= w_flag_nxt;
         r_flash_cnt      <= w_flash_cnt_nxt;
         r_flash_hidden   <= w_flash_hidden_nxt;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_hit_cnt_nxt      = r_hit_cnt;
      w_hit_mask_nxt     = r_hit_mask;
      w_flag_nxt         = r_collision_flag;
      w_flash_cnt_nxt    = r_flash_cnt;
      w_flash_hidden_nxt = r_flash_hidden;

      unique case (r_state)
         PLAY: begin
            if (frame_tick) begin
               if (|r_frame_hit_mask) begin
                  w_hit_cnt_nxt = r_hit_cnt + c_CNT_W'(1);
                  if (r_hit_cnt == c_HIT_LAST) begin
                     w_state_nxt        = GAME_OVER;
                     w_hit_mask_nxt     = r_frame_hit_mask;
                     w_flag_nxt         = 1'b1;
                     // Every GAME OVER starts in the visible flash phase.
                     w_flash_cnt_nxt    = '0;
                     w_flash_hidden_nxt = 1'b0;
                  end
               end else begin
                  w_hit_cnt_nxt = '0;
               end
            end
         end

         GAME_OVER: begin
            // restart has priority over a coincident frame_tick.
            if (restart) begin
               w_state_nxt    = CLEAR;
               w_hit_cnt_nxt  = '0;
               w_hit_mask_nxt = '0;
               w_flag_nxt     = 1'b0;
            end else if (frame_tick) begin
               if (r_flash_cnt == c_FLASH_LAST) begin
                  w_flash_cnt_nxt    = '0;
                  w_flash_hidden_nxt = ~r_flash_hidden;
               end else begin
                  w_flash_cnt_nxt = r_flash_cnt + c_FLASH_W'(1);
               end
            end
         end

         CLEAR: begin
            // Waiting for a frame boundary discards the partial frame.
            if (frame_tick) begin
               w_state_nxt = PLAY;
            end
         end

         default: begin
            w_state_nxt = PLAY;
         end
      endcase
   end

   // ---------------------------------------------------------------- banner
   assign w_show = r_collision_flag & ~r_flash_hidden;

   banner_overlay #(
      .BANNER_X (BANNER_X),
      .BANNER_Y (BANNER_Y),
      .BANNER_W (BANNER_W),
      .BANNER_H (BANNER_H),
      .ROM_AW   (ROM_AW)
   ) u_banner_overlay (
      .clk           (clk),
      .reset_n       (reset_n),
      .pix_row       (pix_row),
      .pix_col       (pix_col),
      .video_on      (video_on),
      .show          (w_show),
      .rom_data      (rom_data),
      .rom_addr      (rom_addr),
      .overlay_valid (overlay_valid),
      .overlay_pix   (overlay_pix)
   );

   assign collision_flag = r_collision_flag;
   assign hit_mask       = r_hit_mask;
   assign game_state     = r_state;

endmodule : collision_game_over_ctrl
`default_nettype wire

// File: tb/tb_collision_game_over_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_collision_game_over_ctrl                                |
// | Description : Self-checking bench for collision_game_over_ctrl with a    |
// |               frame-level reference model and an emulated banner ROM.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_collision_game_over_ctrl;

   localparam int NCARS  = 4;
   localparam int HITF   = 2;
   localparam int FLASHF = 2;
   localparam int BX = 243, BY = 232, BW = 135, BH = 16;
   localparam int M_PLAY = 0, M_GO = 1, M_CLEAR = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  pix_row, pix_col;
   logic        video_on, frame_tick, restart;
   logic [11:0] player_pix;
   logic [47:0] car_pix;
   logic [11:0] rom_addr;
   logic [3:0]  rom_data;
   logic        collision_flag;
   logic [3:0]  hit_mask;
   logic [1:0]  game_state;
   logic        overlay_valid;
   logic [11:0] overlay_pix;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int         m_state;
   int         m_cnt;
   int         m_go_frames;
   logic [3:0] m_frame_mask;
   logic [3:0] m_hit_mask;

   logic [12:0] exp_q[$];
   logic [12:0] chk_exp[$];
   logic [12:0] chk_obs[$];
   bit          rom_force = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [3:0] rom_fn(input logic [11:0] a);
      return a[3:0] ^ a[7:4] ^ a[11:8] ^ 4'h5;
   endfunction

   function automatic bit opq(input logic [11:0] c);
      return (c != 12'h000) && (c != 12'hFFF);
   endfunction

   function automatic logic [11:0] pick_col();
      case ($urandom_range(0, 3))
         0:       return 12'h000;
         1:       return 12'hFFF;
         default: return 12'($urandom);
      endcase
   endfunction

   assign rom_data = rom_force ? 4'hA : rom_fn(rom_addr);

   collision_game_over_ctrl #(
      .NUM_CARS(NCARS), .HIT_FRAMES(HITF), .FLASH_FRAMES(FLASHF),
      .BANNER_X(BX), .BANNER_Y(BY), .BANNER_W(BW), .BANNER_H(BH), .ROM_AW(12)
   ) dut (
      .clk(clk), .reset_n(reset_n), .pix_row(pix_row), .pix_col(pix_col),
      .video_on(video_on), .frame_tick(frame_tick), .restart(restart),
      .player_pix(player_pix), .car_pix(car_pix), .rom_addr(rom_addr),
      .rom_data(rom_data), .collision_flag(collision_flag), .hit_mask(hit_mask),
      .game_state(game_state), .overlay_valid(overlay_valid), .overlay_pix(overlay_pix)
   );

   task automatic model_reset();
      m_state = M_PLAY; m_cnt = 0; m_go_frames = 0;
      m_frame_mask = '0; m_hit_mask = '0;
      exp_q.delete(); chk_exp.delete(); chk_obs.delete();
   endtask

   // One pixel clock: drive inputs, predict the overlay for this pixel,
   // advance the model across the closing edge, and queue the overlay
   // observed for the pixel driven two cycles earlier.
   task automatic drive_cycle(input logic [9:0] row, input logic [9:0] col,
                              input logic von, input logic tick, input logic rs,
                              input logic [11:0] pl, input logic [47:0] cars);
      logic [12:0] e;
      logic [11:0] a;
      logic [3:0]  d;
      bit          win, show;
      @(posedge clk); #1;
      pix_row = row; pix_col = col; video_on = von; frame_tick = tick;
      restart = rs; player_pix = pl; car_pix = cars;
      win  = (int'(row) >= BY) && (int'(row) < BY + BH) &&
             (int'(col) >= BX) && (int'(col) < BX + BW);
      show = (m_state == M_GO) && (((m_go_frames / FLASHF) % 2) == 0);
      if (win && von && show) begin
         a = 12'((int'(row) - BY) * 256 + (int'(col) - BX));
         d = rom_force ? 4'hA : rom_fn(a);
         e = {1'b1, d, d, d};
      end else begin
         e = '0;
      end
      exp_q.push_back(e);
      if (m_state == M_GO && rs) begin
         m_state = M_CLEAR; m_cnt = 0; m_hit_mask = '0;
      end else if (tick) begin
         if (m_state == M_PLAY) begin
            if (m_frame_mask != 0) begin
               m_cnt++;
               if (m_cnt >= HITF) begin
                  m_state = M_GO; m_hit_mask = m_frame_mask; m_go_frames = 0;
               end
            end else begin
               m_cnt = 0;
            end
         end else if (m_state == M_GO) begin
            m_go_frames++;
         end else begin
            m_state = M_PLAY;
         end
      end
      if (tick) m_frame_mask = '0;
      else
         for (int i = 0; i < NCARS; i++)
            if (von && opq(pl) && opq(cars[12*i +: 12])) m_frame_mask[i] = 1'b1;
      @(negedge clk);
      if (exp_q.size() > 2) begin
         chk_exp.push_back(exp_q.pop_front());
         chk_obs.push_back({overlay_valid, overlay_pix});
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive_cycle(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 12'h000, 48'h0);
   endtask

   // A frame: npix pixels (the first always visible with full colours),
   // then a blanking cycle carrying frame_tick.
   task automatic drive_frame(input int npix, input logic [11:0] pl, input logic [47:0] cars,
                              input bit banner, input bit rs_at_tick);
      logic [9:0]  r, c;
      logic [11:0] p;
      logic [47:0] cs;
      for (int k = 0; k < npix; k++) begin
         if (banner) begin
            r = (k == 0) ? 10'(BY + 1) : 10'(BY - 2 + int'($urandom_range(0, BH + 3)));
            c = (k == 0) ? 10'(BX + 5) : 10'(BX - 3 + int'($urandom_range(0, BW + 5)));
         end else begin
            r = 10'($urandom_range(0, 479));
            c = 10'($urandom_range(0, 639));
         end
         if (k == 0) begin
            drive_cycle(r, c, 1'b1, 1'b0, 1'b0, pl, cars);
         end else begin
            p = $urandom_range(0, 1) ? pl : 12'h000;
            for (int i = 0; i < NCARS; i++)
               cs[12*i +: 12] = $urandom_range(0, 1) ? cars[12*i +: 12] : 12'h000;
            drive_cycle(r, c, ($urandom_range(0, 4) != 0), 1'b0, 1'b0, p, cs);
         end
      end
      drive_cycle(10'd0, 10'd0, 1'b0, 1'b1, rs_at_tick, 12'h000, 48'h0);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; pix_row = '0; pix_col = '0; video_on = 1'b0; frame_tick = 1'b0;
      restart = 1'b0; player_pix = '0; car_pix = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (collision_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %b want 0", collision_flag); end
      n_checks++; if (hit_mask !== 4'h0) begin n_fail++; $display("FAIL reset_mask: got %h want 0", hit_mask); end
      n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", game_state); end
      n_checks++; if (overlay_valid !== 1'b0 || overlay_pix !== 12'h000) begin n_fail++; $display("FAIL reset_overlay: got %b/%h want 0/000", overlay_valid, overlay_pix); end
      n_checks++; if (rom_addr !== 12'h000) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 000", rom_addr); end
      reset_n = 1'b1;
   endtask

   task automatic test_collision();
      drive_frame(10, 12'hF00, {12'h000, 12'h000, 12'h0F0, 12'h000}, 0, 0);
      idle(1);
      n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL coll_after_f1: state %0d want 0", game_state); end
      drive_frame(10, 12'hF00, {12'h000, 12'h000, 12'h0F0, 12'h000}, 0, 0);
      n_checks++; if (collision_flag !== 1'b0) begin n_fail++; $display("FAIL coll_tick_cycle: flag %b want 0", collision_flag); end
      idle(1);
      n_checks++; if (collision_flag !== 1'b1) begin n_fail++; $display("FAIL coll_flag: got %b want 1", collision_flag); end
      n_checks++; if (hit_mask !== 4'b0010) begin n_fail++; $display("FAIL coll_mask: got %b want 0010", hit_mask); end
      n_checks++; if (game_state !== 2'(m_state) || m_state != M_GO) begin n_fail++; $display("FAIL coll_state: got %0d model %0d want 1", game_state, m_state); end
   endtask

   task automatic test_banner();
      idle(2); rom_force = 1'b1; idle(2);
      drive_cycle(10'd232, 10'd243, 1'b1, 1'b0, 1'b0, 12'h000, 48'h0);
      drive_cycle(10'd232, 10'd378, 1'b1, 1'b0, 1'b0, 12'h000, 48'h0);
      n_checks++; if (rom_addr !== 12'h000) begin n_fail++; $display("FAIL banner_addr0: got %h want 000", rom_addr); end
      drive_cycle(10'd247, 10'd377, 1'b1, 1'b0, 1'b0, 12'h000, 48'h0);
      n_checks++; if (overlay_valid !== 1'b1 || overlay_pix !== 12'hAAA) begin n_fail++; $display("FAIL banner_first: got %b/%h want 1/AAA", overlay_valid, overlay_pix); end
      idle(1);
      n_checks++; if (overlay_valid !== 1'b0) begin n_fail++; $display("FAIL banner_col378: valid %b want 0", overlay_valid); end
      n_checks++; if (rom_addr !== 12'hF86) begin n_fail++; $display("FAIL banner_addr_corner: got %h want F86", rom_addr); end
      idle(1);
      n_checks++; if (overlay_valid !== 1'b1 || overlay_pix !== 12'hAAA) begin n_fail++; $display("FAIL banner_corner: got %b/%h want 1/AAA", overlay_valid, overlay_pix); end
      n_checks++; if (rom_addr !== 12'hF86) begin n_fail++; $display("FAIL banner_addr_hold: got %h want F86", rom_addr); end
      idle(2); rom_force = 1'b0; idle(2);
      while (chk_exp.size() > 0) begin
         logic [12:0] e, o;
         e = chk_exp.pop_front(); o = chk_obs.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL banner_overlay: got %b/%h want %b/%h", o[12], o[11:0], e[12], e[11:0]); end
      end
   endtask

   task automatic test_restart();
      drive_frame(8, 12'hF00, {12'h00F, 12'h000, 12'h0F0, 12'h000}, 0, 1);
      idle(1);
      n_checks++; if (game_state !== 2'd2 || collision_flag !== 1'b0 || hit_mask !== 4'h0) begin n_fail++; $display("FAIL restart_clear: state %0d flag %b mask %h want 2/0/0", game_state, collision_flag, hit_mask); end
      drive_frame(8, 12'hF00, {12'h000, 12'h000, 12'h0F0, 12'h000}, 0, 0);
      idle(1);
      n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL restart_play: state %0d want 0", game_state); end
      drive_frame(8, 12'hF00, {12'h000, 12'h000, 12'h0F0, 12'h000}, 0, 0);
      idle(1);
      n_checks++; if (game_state !== 2'd0) begin n_fail++; $display("FAIL restart_partial_uncounted: state %0d want 0", game_state); end
      drive_frame(8, 12'hF00, {12'h000, 12'h000, 12'h0F0, 12'h000}, 1, 0);
      idle(1);
      n_checks++; if (game_state !== 2'd1 || collision_flag !== 1'b1) begin n_fail++; $display("FAIL restart_reenter: state %0d flag %b want 1/1", game_state, collision_flag); end
      drive_cycle(10'd233, 10'd250, 1'b1, 1'b0, 1'b0, 12'h000, 48'h0);
      drive_cycle(10'd233, 10'd251, 1'b1, 1'b0, 1'b0, 12'h000, 48'h0);
      #2 reset_n = 1'b0;
      #1;
      n_checks++; if (collision_flag !== 1'b0 || hit_mask !== 4'h0 || game_state !== 2'd0) begin n_fail++; $display("FAIL async_reset_status: flag %b mask %h state %0d want 0", collision_flag, hit_mask, game_state); end
      n_checks++; if (overlay_valid !== 1'b0 || overlay_pix !== 12'h000 || rom_addr !== 12'h000) begin n_fail++; $display("FAIL async_reset_overlay: %b/%h addr %h want 0", overlay_valid, overlay_pix, rom_addr); end
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_counter_reset();
      drive_frame(8, 12'h0F0, {12'h000, 12'h000, 12'h000, 12'h123}, 0, 0);
      drive_frame(8, 12'h0F0, 48'h0, 0, 0);
      drive_frame(8, 12'h0F0, {12'h000, 12'h000, 12'h000, 12'h123}, 0, 0);
      idle(1);
      n_checks++; if (game_state !== 2'd0 || m_state != M_PLAY) begin n_fail++; $display("FAIL counter_reset: state %0d model %0d want 0", game_state, m_state); end
      drive_frame(8, 12'h0F0, 48'h0, 0, 0);
   endtask

   task automatic test_transparent();
      for (int f = 0; f < 3; f++) begin
         drive_frame(10, 12'hF00, {12'hFFF, 12'h000, 12'hFFF, 12'h000}, 0, 0);
         idle(1);
         n_checks++; if (game_state !== 2'd0 || hit_mask !== 4'h0) begin n_fail++; $display("FAIL transparent_f%0d: state %0d mask %h want 0/0", f, game_state, hit_mask); end
      end
   endtask

   task automatic test_flash();
      logic [4:0] pattern;
      bit         any_valid;
      pattern = 5'b10011;  // bit k = frame k+1 after entry: on,on,off,off,on
      drive_frame(6, 12'h00F, {12'h000, 12'h0F0, 12'h000, 12'h000}, 0, 0);
      drive_frame(6, 12'h00F, {12'h000, 12'h0F0, 12'h000, 12'h000}, 0, 0);
      idle(1);
      n_checks++; if (hit_mask !== 4'b0100) begin n_fail++; $display("FAIL flash_mask: got %b want 0100", hit_mask); end
      for (int k = 0; k < 5; k++) begin
         chk_exp.delete(); chk_obs.delete();
         drive_frame(12, 12'h000, 48'h0, 1, 0);
         idle(2);
         any_valid = 1'b0;
         while (chk_exp.size() > 0) begin
            logic [12:0] e, o;
            e = chk_exp.pop_front(); o = chk_obs.pop_front();
            any_valid |= o[12];
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL flash_overlay_f%0d: got %b/%h want %b/%h", k, o[12], o[11:0], e[12], e[11:0]); end
         end
         n_checks++;
         if (any_valid !== pattern[k]) begin n_fail++; $display("FAIL flash_phase_f%0d: visible %b want %b", k, any_valid, pattern[k]); end
      end
   endtask

   task automatic test_random();
      logic [47:0] cs;
      for (int f = 0; f < 30; f++) begin
         for (int i = 0; i < NCARS; i++) cs[12*i +: 12] = pick_col();
         if ($urandom_range(0, 5) == 0) drive_cycle(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 12'h000, 48'h0);
         drive_frame(int'($urandom_range(6, 20)), pick_col(), cs,
                     bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
         idle(1);
         n_checks++;
         if (game_state !== 2'(m_state) || collision_flag !== (m_state == M_GO) || hit_mask !== m_hit_mask) begin
            n_fail++;
            $display("FAIL random_status_f%0d: state %0d flag %b mask %h want %0d/%b/%h", f, game_state, collision_flag, hit_mask, m_state, (m_state == M_GO), m_hit_mask);
         end
         while (chk_exp.size() > 0) begin
            logic [12:0] e, o;
            e = chk_exp.pop_front(); o = chk_obs.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL random_overlay_f%0d: got %b/%h want %b/%h", f, o[12], o[11:0], e[12], e[11:0]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_collision();
      test_banner();
      test_restart();
      test_counter_reset();
      test_transparent();
      test_flash();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
      $fatal(1, "timeout");
   end

endmodule : tb_collision_game_over_ctrl
`default_nettype wire
